// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_pkg
// Purpose  : Shared definitions for the load/store unit: RV32 funct3 size
//            codes, the controller state enum and size helpers.
// Ports    : (package, none)
// Revision : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

   localparam logic [2:0] c_F3_B  = 3'd0;   // LB / SB
   localparam logic [2:0] c_F3_H  = 3'd1;   // LH / SH
   localparam logic [2:0] c_F3_W  = 3'd2;   // LW / SW
   localparam logic [2:0] c_F3_BU = 3'd4;   // LBU
   localparam logic [2:0] c_F3_HU = 3'd5;   // LHU

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC1 = 2'd1,
      ACC2 = 2'd2,
      RESP = 2'd3
   } lsu_state_t;

   // Byte-lane mask for an access of the size encoded in funct3[1:0].
   function automatic logic [3:0] size_to_mask(input logic [1:0] i_sz);
      case (i_sz)
         2'd0:    return 4'b0001;
         2'd1:    return 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Access size in bytes for the size encoded in funct3[1:0].
   function automatic logic [2:0] size_to_bytes(input logic [1:0] i_sz);
      case (i_sz)
         2'd0:    return 3'd1;
         2'd1:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Purpose  : Combinational data alignment. Positions store data and byte
//            enables across the two words an access may touch, and extracts
//            plus sign/zero-extends load data from those two words.
// Ports    : i_off     byte offset within the first word
//            i_funct3  RV32 size/sign code
//            i_wdata   right-aligned store data
//            i_word0   first word read, i_word1 second word read (0 if none)
//            o_ld_data extended load result
//            o_wd_lo/o_wd_hi, o_we_lo/o_we_hi  store data/enables per word
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
   import load_store_unit_pkg::*;
(
   input  logic [1:0]  i_off,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_word0,
   input  logic [31:0] i_word1,
   output logic [31:0] o_ld_data,
   output logic [31:0] o_wd_lo,
   output logic [31:0] o_wd_hi,
   output logic [3:0]  o_we_lo,
   output logic [3:0]  o_we_hi
);

   logic [5:0]  w_shamt;
   logic [63:0] w_st_wide;
   logic [7:0]  w_we_wide;
   logic [31:0] w_ld_raw;

   assign w_shamt = {1'b0, i_off, 3'b000};

   // Shifting into a double-width vector splits the data naturally: the low
   // half belongs to the first word, whatever spills goes to the next word.
   assign w_st_wide = {32'h0, i_wdata} << w_shamt;
   assign w_we_wide = {4'h0, size_to_mask(i_funct3[1:0])} << i_off;

   assign o_wd_lo = w_st_wide[31:0];
   assign o_wd_hi = w_st_wide[63:32];
   assign o_we_lo = w_we_wide[3:0];
   assign o_we_hi = w_we_wide[7:4];

   assign w_ld_raw = 32'({i_word1, i_word0} >> w_shamt);

   always_comb begin
      o_ld_data = w_ld_raw;
      case (i_funct3)
         c_F3_B:  o_ld_data = {{24{w_ld_raw[7]}}, w_ld_raw[7:0]};
         c_F3_H:  o_ld_data = {{16{w_ld_raw[15]}}, w_ld_raw[15:0]};
         c_F3_BU: o_ld_data = {24'h0, w_ld_raw[7:0]};
         c_F3_HU: o_ld_data = {16'h0, w_ld_raw[15:0]};
         default: o_ld_data = w_ld_raw;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : RV32 load/store unit. Accepts one request at a time, performs
//            one or two word accesses (two when the access crosses a word
//            boundary) on a combinational-read memory, and holds the
//            response until the core takes it.
// Ports    : clk, rst_n (async active-low)
//            i_req_*/o_req_ready   core request handshake
//            o_resp_*/i_resp_ready core response handshake
//            o_daddr, o_dwdata, o_we, i_drdata  word memory port
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int MEM_BYTES = 128
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_store,
   input  logic [2:0]  i_req_funct3,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   output logic        o_resp_valid,
   input  logic        i_resp_ready,
   output logic [31:0] o_resp_rdata,
   output logic        o_resp_err,
   output logic [31:0] o_daddr,
   output logic [31:0] o_dwdata,
   output logic [3:0]  o_we,
   input  logic [31:0] i_drdata
);

   lsu_state_t  r_state;
   logic        r_store;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_err;
   logic        r_cross;
   logic [31:0] r_word0;

   logic        w_idle;
   logic        w_store;
   logic [2:0]  w_funct3;
   logic [31:0] w_addr;
   logic [31:0] w_wdata;
   logic        w_legal;
   logic [2:0]  w_size;
   logic [32:0] w_end;
   logic        w_err_new;
   logic        w_cross_new;
   logic [31:0] w_word0;
   logic [31:0] w_word1;
   logic [31:0] w_ld_data;
   logic [31:0] w_wd_lo;
   logic [31:0] w_wd_hi;
   logic [3:0]  w_we_lo;
   logic [3:0]  w_we_hi;

   // Outputs are registered, so the first access is set up on the accept
   // edge straight from the request inputs; afterwards the captured copy
   // drives the alignment logic.
   assign w_idle   = (r_state == IDLE);
   assign w_store  = w_idle ? i_req_store  : r_store;
   assign w_funct3 = w_idle ? i_req_funct3 : r_funct3;
   assign w_addr   = w_idle ? i_req_addr   : r_addr;
   assign w_wdata  = w_idle ? i_req_wdata  : r_wdata;

   always_comb begin
      w_legal = 1'b0;
      if (w_store)
         w_legal = (w_funct3 == c_F3_B) || (w_funct3 == c_F3_H) || (w_funct3 == c_F3_W);
      else
         w_legal = (w_funct3 == c_F3_B)  || (w_funct3 == c_F3_H)  || (w_funct3 == c_F3_W) ||
                   (w_funct3 == c_F3_BU) || (w_funct3 == c_F3_HU);
   end

   assign w_size      = size_to_bytes(w_funct3[1:0]);
   // 33-bit end address so an access near 2^32 cannot wrap into range.
   assign w_end       = {1'b0, w_addr} + {30'h0, w_size};
   assign w_err_new   = !w_legal || (w_end > 33'(MEM_BYTES));
   assign w_cross_new = ({1'b0, w_addr[1:0]} + w_size) > 3'd4;

   // Word0 is live on the bus during ACC1, word1 during ACC2; word1 stays 0
   // for a non-crossing access.
   assign w_word0 = (r_state == ACC1) ? i_drdata : r_word0;
   assign w_word1 = (r_state == ACC2) ? i_drdata : 32'h0;

   lsu_align u_align (
      .i_off     (w_addr[1:0]),
      .i_funct3  (w_funct3),
      .i_wdata   (w_wdata),
      .i_word0   (w_word0),
      .i_word1   (w_word1),
      .o_ld_data (w_ld_data),
      .o_wd_lo   (w_wd_lo),
      .o_wd_hi   (w_wd_hi),
      .o_we_lo   (w_we_lo),
      .o_we_hi   (w_we_hi)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_store      <= 1'b0;
         r_funct3     <= 3'h0;
         r_addr       <= 32'h0;
         r_wdata      <= 32'h0;
         r_err        <= 1'b0;
         r_cross      <= 1'b0;
         r_word0      <= 32'h0;
         o_req_ready  <= 1'b1;
         o_resp_valid <= 1'b0;
         o_resp_rdata <= 32'h0;
         o_resp_err   <= 1'b0;
         o_daddr      <= 32'h0;
         o_dwdata     <= 32'h0;
         o_we         <= 4'h0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_req_valid) begin
                  r_store     <= i_req_store;
                  r_funct3    <= i_req_funct3;
                  r_addr      <= i_req_addr;
                  r_wdata     <= i_req_wdata;
                  r_err       <= w_err_new;
                  r_cross     <= w_cross_new;
                  r_state     <= ACC1;
                  o_req_ready <= 1'b0;
                  o_daddr     <= {i_req_addr[31:2], 2'b00};
                  o_dwdata    <= w_wd_lo;
                  o_we        <= (i_req_store && !w_err_new) ? w_we_lo : 4'h0;
               end
            end
            ACC1: begin
               r_word0 <= i_drdata;
               if (!r_err && r_cross) begin
                  r_state  <= ACC2;
                  o_daddr  <= {r_addr[31:2], 2'b00} + 32'd4;
                  o_dwdata <= w_wd_hi;
                  o_we     <= r_store ? w_we_hi : 4'h0;
               end else begin
                  r_state      <= RESP;
                  o_daddr      <= 32'h0;
                  o_dwdata     <= 32'h0;
                  o_we         <= 4'h0;
                  o_resp_valid <= 1'b1;
                  o_resp_err   <= r_err;
                  o_resp_rdata <= (r_err || r_store) ? 32'h0 : w_ld_data;
               end
            end
            ACC2: begin
               r_state      <= RESP;
               o_daddr      <= 32'h0;
               o_dwdata     <= 32'h0;
               o_we         <= 4'h0;
               o_resp_valid <= 1'b1;
               o_resp_err   <= 1'b0;
               o_resp_rdata <= r_store ? 32'h0 : w_ld_data;
            end
            RESP: begin
               if (i_resp_ready) begin
                  r_state      <= IDLE;
                  o_req_ready  <= 1'b1;
                  o_resp_valid <= 1'b0;
                  o_resp_err   <= 1'b0;
                  o_resp_rdata <= 32'h0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 128, data-memory size in bytes; accesses beyond it are errors.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have core request ports: req_valid in 1, request present; req_ready out 1, unit can accept; req_store in 1, 1=store 0=load; req_funct3 in 3, RV32 size/sign code; req_addr in 32, byte address; req_wdata in 32, store data, right-aligned.
REQ-004 SHALL have core response ports: resp_valid out 1, response held; resp_ready in 1, core takes response; resp_rdata out 32, extended load data (0 for stores); resp_err out 1, misfunct or out-of-range.
REQ-005 SHALL have memory ports: daddr out 32, word-aligned address; dwdata out 32, lane-positioned write data; we out 4, byte-lane write enables; drdata in 32, combinational word read, byte 0 in [7:0].

Function
REQ-006 SHALL implement states IDLE, ACC1, ACC2, RESP; req_ready=1 only in IDLE.
REQ-007 SHALL capture store, funct3, addr and wdata on the edge where req_valid&&req_ready, then enter ACC1.
REQ-008 Legal funct3 SHALL be loads 0(LB),1(LH),2(LW),4(LBU),5(LHU) and stores 0(SB),1(SH),2(SW); any other code sets err.
REQ-009 Size bytes SHALL be 1/2/4; off=addr[1:0]; access SHALL cross when off+size>4.
REQ-010 Out-of-range SHALL mean addr+size>MEM_BYTES, computed in 33 bits so no wrap.
REQ-011 Error requests SHALL go ACC1->RESP with we=0 throughout, resp_err=1, resp_rdata=0.
REQ-012 ACC1 SHALL drive daddr=addr&~3, we=(mask<<off)[3:0] for stores, else 0, and dwdata=wdata<<(8*off); mask=1/3/F for size 1/2/4.
REQ-013 ACC1 SHALL register drdata as word0, then go to ACC2 if crossing, else RESP.
REQ-014 ACC2 SHALL drive daddr=(addr&~3)+4, we=mask>>(4-off) for stores, dwdata=wdata>>(8*(4-off)), register drdata as word1, then go to RESP.
REQ-015 Load data SHALL be ({word1,word0}>>8*off) truncated to size; LB/LH sign-extend, LBU/LHU/LW zero-extend; word1 is 0 when not crossing.
REQ-016 RESP SHALL hold resp_valid=1 and stable outputs until resp_ready=1, then return to IDLE on that edge.
REQ-017 Latency SHALL be: accept edge, then one (aligned) or two (crossing) access cycles, then resp_valid; a new request SHALL be accepted no earlier than the cycle after the response handshake.
REQ-018 we SHALL be 0 in IDLE and RESP, and for all loads.
REQ-019 daddr and dwdata SHALL be 0 in IDLE and RESP.

Reset
REQ-020 rst_n low SHALL immediately force state=IDLE, we=0, req_ready=1 and clear resp_valid, resp_err, resp_rdata, daddr, dwdata and captured registers, with no clock required.
REQ-021 Reset asserted between ACC1 and ACC2 of a crossing store SHALL abort ACC2; only ACC1 bytes remain written.
REQ-022 First request acceptance SHALL occur no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-023 A shared package SHALL hold the funct3 encodings, the state enum, and a size-to-mask function.
REQ-024 One sub-module, lsu_align, SHALL be used: a combinational load extract/extend and store lane shift, instantiated once.

Verification (memory bytes 8..15 preset 88,99,AA,BB,CC,DD,EE,FF; MEM_BYTES=128)
REQ-025 LW addr 8 -> one access with daddr=8, we=0; resp_rdata=BBAA9988, err=0, resp_valid in the second cycle after accept.
REQ-026 LH addr 9 -> resp_rdata=FFFFAA99; LHU addr 11 (crossing) -> daddr 8 then 12, resp_rdata=0000CCBB.
REQ-027 SW wdata=11223344 addr 10 -> ACC1 we=1100, dwdata=33440000 @8; ACC2 we=0011, dwdata=00001122 @12; then LW 8 -> 3344 9988 and LW 12 -> FFEE1122.
REQ-028 SW addr 126 -> err=1, we never nonzero, rdata=0; load funct3=3 -> err=1.
REQ-029 resp_ready held low 5 cycles -> resp_valid and rdata stable, req_ready=0 throughout.
REQ-030 rst_n low during ACC2 of crossing SH FFEE @ addr 15 -> we=0 immediately, state IDLE; byte 15=EE, byte 16 unchanged.
